ps2_scancode_receiver: RTL



---
 rtl/ps2_scancode_receiver.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronizes and debounces kb_clk, deserializes 11-bit frames
// and emits scan-code bytes with a one-cycle strobe, a 4-byte history word and error pulses.
module ps2_scancode_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kb_clk,
    input  logic        kb_data,
    output logic [7:0]  code,
    output logic        code_valid,
    output logic [31:0] keycodeout,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [7:0]    filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_tick_q, to_tick_d;
    logic [7:0]    code_q, code_d;
    logic [31:0]   hist_q, hist_d;
    logic          code_valid_q, code_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

    logic clk_s, data_s, fall, timeout;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall       = 1'b0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = clk_s;
                fall   = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end
    end

    // The timeout counter advances on alternate cycles and is held clear while idle.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        to_tick_d = ~to_tick_q;
        if (fall || state_q == IDLE) begin
            to_cnt_d  = '0;
            to_tick_d = 1'b0;
        end else if (to_tick_q) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // An edge in the same cycle suppresses the timeout.
    assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        code_d       = code_q;
        hist_d       = hist_q;
        code_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else if (^{shift_q, parity_q} == 1'b0) begin
                        parity_err_d = 1'b1;
                    end else begin
                        code_d       = shift_q;
                        hist_d       = {hist_q[23:0], shift_q};
                        code_valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            to_tick_q    <= 1'b0;
            code_q       <= '0;
            hist_q       <= '0;
            code_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], kb_clk};
            data_sync_q  <= {data_sync_q[0], kb_data};
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            to_tick_q    <= to_tick_d;
            code_q       <= code_d;
            hist_q       <= hist_d;
            code_valid_q <= code_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign code       = code_q;
    assign keycodeout = hist_q;
    assign code_valid = code_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule
